// File: rtl/cpu_dma.sv
// Cycle-stealing DMA controller sharing one memory bus with a CPU: block copies to a fixed
// destination and single-byte fetches. Define CPU_DMA_PARITY_ALIGN_EN to enable the ALIGN state.
module cpu_dma #(
    parameter int          NCH      = 2,
    parameter int          LEN_W    = 8,
    parameter logic [15:0] DST_ADDR = 16'h2004
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cpu_en,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         mode,
    input  logic [16*NCH-1:0]      src_addr,
    input  logic [LEN_W*NCH-1:0]   len,
    input  logic [15:0]            cpu_addr,
    input  logic [7:0]             cpu_wdata,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    output logic [15:0]            mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_read,
    output logic                   mem_write,
    input  logic [7:0]             mem_rdata,
    output logic                   cpu_rdy,
    output logic                   busy,
    output logic [NCH-1:0]         done,
    output logic [7:0]             fetch_data,
    output logic [NCH-1:0]         fetch_valid
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        FETCH = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [NCH-1:0]    pending_q, pending_d;
    logic [NCH-1:0]    done_q, done_d;
    logic [NCH-1:0]    fvalid_q, fvalid_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              parity_q, parity_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        fdata_q, fdata_d;
`ifdef CPU_DMA_PARITY_ALIGN_EN
    logic              grant_par_q, grant_par_d;
`endif

    logic              anyPending;
    logic [CH_W-1:0]   grantIdx;
    logic [NCH-1:0]    grantMask;
    logic [15:0]       chSrc;
    logic [LEN_W-1:0]  chLen;
    logic              chMode;
    logic [NCH-1:0]    chanMask;
    logic [15:0]       readAddr;

    // Lowest pending index wins; grantMask isolates the lowest set bit.
    always_comb begin
        anyPending = |pending_q;
        grantMask  = pending_q & (~pending_q + NCH'(1));
        grantIdx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grantIdx = CH_W'(i);
            end
        end
    end

    always_comb begin
        chSrc    = '0;
        chLen    = '0;
        chMode   = 1'b0;
        chanMask = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chan_q == CH_W'(i)) begin
                chSrc       = src_addr[16*i +: 16];
                chLen       = len[LEN_W*i +: LEN_W];
                chMode      = mode[i];
                chanMask[i] = 1'b1;
            end
        end
    end

    // Source pointer wraps naturally in 16 bits.
    assign readAddr = chSrc + 16'(count_q);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        done_d    = done_q;
        fvalid_d  = fvalid_q;
        chan_d    = chan_q;
        count_d   = count_q;
        parity_d  = parity_q;
        data_d    = data_q;
        fdata_d   = fdata_q;
`ifdef CPU_DMA_PARITY_ALIGN_EN
        grant_par_d = grant_par_q;
`endif
        if (cpu_en) begin
            parity_d  = ~parity_q;
            done_d    = '0;
            fvalid_d  = '0;
            pending_d = pending_q | req;
            case (state_q)
                IDLE: begin
                    if (anyPending && !cpu_write) begin
                        pending_d = (pending_q & ~grantMask) | req;
                        chan_d    = grantIdx;
                        count_d   = '0;
                        state_d   = HALT;
`ifdef CPU_DMA_PARITY_ALIGN_EN
                        grant_par_d = parity_q;
`endif
                    end
                end
                HALT: begin
                    if (chMode) begin
                        state_d = FETCH;
                    end else begin
`ifdef CPU_DMA_PARITY_ALIGN_EN
                        // Alignment follows the parity seen on the granting tick.
                        state_d = grant_par_q ? ALIGN : READ;
`else
                        state_d = READ;
`endif
                    end
                end
                ALIGN: begin
                    state_d = READ;
                end
                READ: begin
                    data_d  = mem_rdata;
                    state_d = WRITE;
                end
                WRITE: begin
                    if (count_q == chLen) begin
                        done_d  = chanMask;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + LEN_W'(1);
                        state_d = READ;
                    end
                end
                FETCH: begin
                    fdata_d  = mem_rdata;
                    fvalid_d = chanMask;
                    done_d   = chanMask;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            done_q    <= '0;
            fvalid_q  <= '0;
            chan_q    <= '0;
            count_q   <= '0;
            parity_q  <= 1'b0;
            data_q    <= '0;
            fdata_q   <= '0;
`ifdef CPU_DMA_PARITY_ALIGN_EN
            grant_par_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            fvalid_q  <= fvalid_d;
            chan_q    <= chan_d;
            count_q   <= count_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            fdata_q   <= fdata_d;
`ifdef CPU_DMA_PARITY_ALIGN_EN
            grant_par_q <= grant_par_d;
`endif
        end
    end

    // The CPU owns the bus only while idle; HALT and ALIGN leave it quiet.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_read  = cpu_read;
                mem_write = cpu_write;
            end
            READ: begin
                mem_addr = readAddr;
                mem_read = 1'b1;
            end
            WRITE: begin
                mem_addr  = DST_ADDR;
                mem_wdata = data_q;
                mem_write = 1'b1;
            end
            FETCH: begin
                mem_addr = chSrc;
                mem_read = 1'b1;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    assign cpu_rdy     = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign fetch_valid = fvalid_q;
    assign fetch_data  = fdata_q;

endmodule
